fifo_wr_source: RTL and testbench
=================================

// Module: fifo_wr_source
// PURPOSE
// Write-domain producer for the async FIFO: drives the FIFO write port (winc/wdata) from an
// upstream valid/ready stream, honouring wfull. Owns the 2-FF rptr synchronizer feeding the
// FIFO write-side pointer logic, and reports registered fill level and almost-full to the producer.
// Sits in the wclk domain between the data source (e.g. register file/ALU) and the FIFO write side.
// PARAMETERS
// DATA_WIDTH   8  width of s_data / wdata
// ADDR_WIDTH   3  FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
// AFULL_THRESH 6  walmost_full asserts when wlevel >= AFULL_THRESH (legal range 1..depth)
// PORTS
// wclk         in   1             write clock
// wrst_n       in   1             reset, asynchronous, active-low
// s_valid      in   1             upstream word valid
// s_data       in   DATA_WIDTH    upstream word
// s_ready      out  1             block can accept a word this cycle
// winc         out  1             FIFO write strobe (word written on wclk edge when winc=1)
// wdata        out  DATA_WIDTH    FIFO write data
// wfull        in   1             FIFO full flag from the write-side pointer logic
// wptr         in   ADDR_WIDTH+1  Gray write pointer from the write-side pointer logic
// rptr         in   ADDR_WIDTH+1  Gray read pointer, read domain (asynchronous to wclk)
// wq2_rptr     out  ADDR_WIDTH+1  rptr after 2-FF synchronization into wclk
// wlevel       out  ADDR_WIDTH+1  registered FIFO occupancy seen from write side, 0..depth
// walmost_full out  1             registered wlevel >= AFULL_THRESH
// BEHAVIOUR
// - Reset (async assert, sync release to wclk): sync flops, wq2_rptr, wlevel, walmost_full,
//   out_valid, skid_valid, s_ready, wdata all 0; any buffered words discarded. Reset mid-stream
//   drops held words; no winc during or on the first edge after reset.
// - Synchronizer: two wclk flops, rptr -> q1 -> wq2_rptr; no logic between stages.
// - Level: Gray->binary of wptr and wq2_rptr; lvl = (wbin - rbin) mod 2**(ADDR_WIDTH+1);
//   wlevel <= lvl, walmost_full <= (lvl >= AFULL_THRESH); 1-cycle latency. Pointer wrap handled
//   by the modulo subtract; lvl==depth when MSBs differ and lower bits equal.
// - Datapath: output register (out_valid, out_data) plus one-entry skid (skid_valid, skid_data).
//   wdata = out_data; winc = out_valid & ~wfull (combinational; wfull is registered upstream).
//   accept = s_valid & s_ready; fire = winc.
// - State (out_valid, skid_valid): EMPTY(0,0), ONE(1,0), TWO(1,1); (0,1) unreachable.
//   EMPTY: accept -> ONE, out<=s_data.
//   ONE: fire&accept -> ONE, out<=s_data; fire&~accept -> EMPTY; ~fire&accept -> TWO, skid<=s_data.
//   TWO: fire -> ONE, out<=skid; ~fire -> TWO. accept impossible in TWO.
// - s_ready registered: s_ready <= ~skid_valid_next. Goes 1 on first edge after reset release.
// - Latency: word accepted at edge N is on wdata with winc=1 from cycle N..N+1 if wfull=0.
//   Throughput 1 word/cycle while wfull=0. Order strictly preserved; no word lost or duplicated.
// - wfull=1: winc=0, out/skid hold; after at most 1 more accept s_ready drops (TWO).
// - wfull deasserting: winc rises same cycle; s_ready returns 1 one cycle after the drain from TWO.
// - s_data is ignored when s_valid=0 or s_ready=0.
// TESTING
// - Reset release, s_valid=1 data 0x11,0x22,0x33 back-to-back, wfull=0 -> winc 1 for 3 cycles,
//   wdata 0x11,0x22,0x33 one cycle after each accept; s_ready stays 1.
// - Hold wfull=1, offer 0xA0,0xA1,0xA2 -> accepts 0xA0,0xA1 only, s_ready=0, winc=0; drop wfull
//   -> wdata 0xA0 then 0xA1 then 0xA2 in order, no loss/duplicate.
// - rptr=4'b0000, wptr=Gray(6) -> after 2 edges wq2_rptr=0, next edge wlevel=6, walmost_full=1;
//   rptr=Gray(3) -> wlevel=3, walmost_full=0 three edges later.
// - Wrap: wptr=Gray(4'b1001), rptr=Gray(4'b0001) -> wlevel=8 (depth); wptr=Gray(1),
//   rptr=Gray(14) -> wlevel=3.
// - Assert wrst_n low while in TWO with wfull=1 -> all outputs 0 asynchronously; after release
//   no winc until a new word is accepted; held words never appear on wdata.
// - Random s_valid/wfull, scoreboard wdata on winc vs accepted s_data -> exact order match.

Source files
------------

// File: rtl/fifo_wr_source.sv
// fifo_wr_source: write-domain producer for the async FIFO.
// Turns an upstream valid/ready stream into FIFO winc/wdata through an output
// register plus a one-entry skid buffer, brings the read pointer into wclk
// with a 2-FF synchronizer, and reports a registered fill level / almost-full.
module fifo_wr_source #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  winc,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wfull,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  walmost_full
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [31:0] AFULL_THRESH_V = AFULL_THRESH;
    localparam logic [PW-1:0] AFULL_LVL = AFULL_THRESH_V[PW-1:0];

    // Encoding chosen so bit 0 is out_valid and bit 1 is skid_valid;
    // the (0,1) combination never occurs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  out_valid;
    logic                  skid_valid_next;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  accept;
    logic                  fire;
    logic [PW-1:0]         rptr_q1;
    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         lvl;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign out_valid       = state[0];
    assign skid_valid_next = state_next[1];
    assign winc            = out_valid & ~wfull;
    assign wdata           = out_data;
    assign accept          = s_valid & s_ready;
    assign fire            = winc;

    // Next occupancy of the output register / skid pair from accept and fire.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (fire && !accept)      state_next = EMPTY;
                else if (!fire && accept) state_next = TWO;
            end
            TWO: if (fire) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Datapath FSM: loads the output register or skid, refills from skid, registers s_ready.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid_data <= '0;
            s_ready   <= 1'b0;
        end else begin
            state   <= state_next;
            s_ready <= ~skid_valid_next;
            case (state)
                EMPTY: if (accept) out_data <= s_data;
                ONE: begin
                    if (fire && accept)       out_data  <= s_data;
                    else if (!fire && accept) skid_data <= s_data;
                end
                TWO: if (fire) out_data <= skid_data;
                default: ;
            endcase
        end
    end

    // Two-stage synchronizer for the Gray read pointer; stages are plain flops.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rptr_q1  <= '0;
            wq2_rptr <= '0;
        end else begin
            rptr_q1  <= rptr;
            wq2_rptr <= rptr_q1;
        end
    end

    // Modulo subtract of binary pointers handles wrap, including the full (== depth) case.
    assign wbin = gray2bin(wptr);
    assign rbin = gray2bin(wq2_rptr);
    assign lvl  = wbin - rbin;

    // Registered level and almost-full flag seen by the producer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= lvl;
            walmost_full <= (lvl >= AFULL_LVL);
        end
    end

endmodule

// File: tb/tb_fifo_wr_source.sv
// tb_fifo_wr_source: self-checking bench for fifo_wr_source.
// Accepted words are queued at handshake time and compared against wdata
// whenever winc is seen; each scenario task also checks its own timing.
module tb_fifo_wr_source;

    logic       wclk   = 1'b0;
    logic       wrst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       wfull = 1'b0;
    logic [3:0] wptr = 4'h0;
    logic [3:0] rptr = 4'h0;
    logic       s_ready;
    logic       winc;
    logic [7:0] wdata;
    logic [3:0] wq2_rptr;
    logic [3:0] wlevel;
    logic       walmost_full;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;

    fifo_wr_source #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (3),
        .AFULL_THRESH(6)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .winc        (winc),
        .wdata       (wdata),
        .wfull       (wfull),
        .wptr        (wptr),
        .rptr        (rptr),
        .wq2_rptr    (wq2_rptr),
        .wlevel      (wlevel),
        .walmost_full(walmost_full)
    );

    // Free-running write clock.
    always #5 wclk = ~wclk;

    // Scoreboard: pop and compare on each write strobe, push on each accepted word.
    always @(negedge wclk) begin
        if (!wrst_n) begin
            sb_q.delete();
            checks++;
            if (winc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sb_winc_in_reset: winc=%b required 0", winc);
            end
        end else begin
            if (winc === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected_write: wdata=%h required no write", wdata);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (wdata !== sb_exp) begin
                        errors++;
                        $display("[TB] FAIL sb_order: wdata=%h required %h", wdata, sb_exp);
                    end
                end
            end
            if (s_valid && s_ready === 1'b1) sb_q.push_back(s_data);
        end
    end

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n  = 1'b0;
        s_valid = 1'b0;
        wfull   = 1'b0;
        wptr    = 4'h0;
        rptr    = 4'b0101;
        repeat (3) @(negedge wclk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b required 0", s_ready); end
        checks++;
        if (winc !== 1'b0) begin errors++; $display("[TB] FAIL reset_winc: got %b required 0", winc); end
        checks++;
        if (wdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_wdata: got %h required 00", wdata); end
        checks++;
        if (wq2_rptr !== 4'h0) begin errors++; $display("[TB] FAIL reset_wq2_rptr: got %h required 0", wq2_rptr); end
        checks++;
        if (wlevel !== 4'h0) begin errors++; $display("[TB] FAIL reset_wlevel: got %h required 0", wlevel); end
        checks++;
        if (walmost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull: got %b required 0", walmost_full); end
        rptr = 4'h0;
        tick();
        wrst_n = 1'b1;
        @(negedge wclk);
        checks++;
        if (s_ready !== 1'b0 || winc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_first_cycle: s_ready=%b winc=%b required 0 0", s_ready, winc);
        end
        tick();
        @(negedge wclk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [0:2];
        d[0] = 8'h11;
        d[1] = 8'h22;
        d[2] = 8'h33;
        wfull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) begin
                s_valid = 1'b1;
                s_data  = d[i];
            end else begin
                s_valid = 1'b0;
            end
            @(negedge wclk);
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_s_ready[%0d]: got %b required 1", i, s_ready); end
            checks++;
            if (i == 0) begin
                if (winc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_winc_idle: got %b required 0", winc); end
            end else if (winc !== 1'b1 || wdata !== d[i-1]) begin
                errors++;
                $display("[TB] FAIL b2b_write[%0d]: winc=%b wdata=%h required 1 %h", i, winc, wdata, d[i-1]);
            end
        end
        tick();
        @(negedge wclk);
        checks++;
        if (winc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_winc_end: got %b required 0", winc); end
    endtask

    task automatic test_wfull();
        tick();
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hA0;
        @(negedge wclk);
        checks++;
        if (s_ready !== 1'b1 || winc !== 1'b0) begin
            errors++; $display("[TB] FAIL full_c1: s_ready=%b winc=%b required 1 0", s_ready, winc);
        end
        tick();
        s_data = 8'hA1;
        @(negedge wclk);
        checks++;
        if (s_ready !== 1'b1 || winc !== 1'b0) begin
            errors++; $display("[TB] FAIL full_c2: s_ready=%b winc=%b required 1 0", s_ready, winc);
        end
        tick();
        s_data = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            checks++;
            if (s_ready !== 1'b0 || winc !== 1'b0 || wdata !== 8'hA0) begin
                errors++;
                $display("[TB] FAIL full_hold[%0d]: s_ready=%b winc=%b wdata=%h required 0 0 a0", i, s_ready, winc, wdata);
            end
        end
        tick();
        wfull = 1'b0;
        @(negedge wclk);
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hA0 || s_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_c1: winc=%b wdata=%h s_ready=%b required 1 a0 0", winc, wdata, s_ready);
        end
        tick();
        @(negedge wclk);
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hA1 || s_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL drain_c2: winc=%b wdata=%h s_ready=%b required 1 a1 1", winc, wdata, s_ready);
        end
        tick();
        s_valid = 1'b0;
        @(negedge wclk);
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hA2) begin
            errors++; $display("[TB] FAIL drain_c3: winc=%b wdata=%h required 1 a2", winc, wdata);
        end
        tick();
        @(negedge wclk);
        checks++;
        if (winc !== 1'b0) begin errors++; $display("[TB] FAIL drain_end: winc=%b required 0", winc); end
    endtask

    task automatic test_level();
        logic [3:0] w_tab [0:5];
        logic [3:0] r_tab [0:5];
        logic [3:0] l_tab [0:5];
        w_tab[0] = 4'd9;  r_tab[0] = 4'd1;  l_tab[0] = 4'd8;
        w_tab[1] = 4'd1;  r_tab[1] = 4'd14; l_tab[1] = 4'd3;
        w_tab[2] = 4'd5;  r_tab[2] = 4'd0;  l_tab[2] = 4'd5;
        w_tab[3] = 4'd6;  r_tab[3] = 4'd0;  l_tab[3] = 4'd6;
        w_tab[4] = 4'd15; r_tab[4] = 4'd7;  l_tab[4] = 4'd8;
        w_tab[5] = 4'd3;  r_tab[5] = 4'd3;  l_tab[5] = 4'd0;

        tick();
        rptr = 4'b0000;
        wptr = gray(4'd6);
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        checks++;
        if (wlevel !== 4'd6 || walmost_full !== 1'b1 || wq2_rptr !== 4'h0) begin
            errors++; $display("[TB] FAIL level6: wlevel=%0d afull=%b wq2=%h required 6 1 0", wlevel, walmost_full, wq2_rptr);
        end
        tick();
        rptr = gray(4'd3);
        @(posedge wclk);
        @(negedge wclk);
        checks++;
        if (wq2_rptr !== 4'h0) begin errors++; $display("[TB] FAIL sync_stage1: wq2=%h required 0", wq2_rptr); end
        @(posedge wclk);
        @(negedge wclk);
        checks++;
        if (wq2_rptr !== 4'b0010 || wlevel !== 4'd6) begin
            errors++; $display("[TB] FAIL sync_stage2: wq2=%h wlevel=%0d required 2 6", wq2_rptr, wlevel);
        end
        @(posedge wclk);
        @(negedge wclk);
        checks++;
        if (wlevel !== 4'd3 || walmost_full !== 1'b0) begin
            errors++; $display("[TB] FAIL level3: wlevel=%0d afull=%b required 3 0", wlevel, walmost_full);
        end

        for (int k = 0; k < 6; k++) begin
            tick();
            wptr = gray(w_tab[k]);
            rptr = gray(r_tab[k]);
            repeat (3) @(posedge wclk);
            @(negedge wclk);
            checks++;
            if (wlevel !== l_tab[k] || walmost_full !== (l_tab[k] >= 4'd6)) begin
                errors++;
                $display("[TB] FAIL level_tab[%0d]: wlevel=%0d afull=%b required %0d %b",
                         k, wlevel, walmost_full, l_tab[k], (l_tab[k] >= 4'd6));
            end
        end
        tick();
        wptr = 4'h0;
        rptr = 4'h0;
        repeat (3) @(posedge wclk);
    endtask

    task automatic test_reset_mid_stream();
        tick();
        wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB0;
        tick();
        s_data = 8'hB1;
        tick();
        s_data = 8'hB2;
        @(negedge wclk);
        checks++;
        if (s_ready !== 1'b0 || winc !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_in_two: s_ready=%b winc=%b required 0 0", s_ready, winc);
        end
        #2;
        wrst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, winc, wdata, wq2_rptr, wlevel, walmost_full} !== 19'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: s_ready=%b winc=%b wdata=%h wlevel=%0d required all 0",
                     s_ready, winc, wdata, wlevel);
        end
        s_valid = 1'b0;
        wfull   = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            checks++;
            if (winc !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_winc[%0d]: got %b required 0", i, winc); end
        end
        tick();
        s_valid = 1'b1;
        s_data  = 8'hC5;
        tick();
        s_valid = 1'b0;
        @(negedge wclk);
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hC5) begin
            errors++; $display("[TB] FAIL post_reset_word: winc=%b wdata=%h required 1 c5", winc, wdata);
        end
        tick();
        @(negedge wclk);
        checks++;
        if (winc !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_end: winc=%b required 0", winc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick();
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom_range(0, 255));
            wfull   = ($urandom_range(0, 3) == 0);
        end
        tick();
        s_valid = 1'b0;
        wfull   = 1'b0;
        repeat (4) tick();
        @(negedge wclk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("[TB] FAIL random_drain: %0d words left required 0", sb_q.size());
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        $display("[TB] start");
        test_reset();
        test_back_to_back();
        test_wfull();
        test_level();
        test_reset_mid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
